pwm_timing_gen: RTL and testbench

- Consumer end of the smoothed-drive interface: takes per-transducer DUTY_S/PHASE_S arrays from the silent LPF and turns them into DEPTH ultrasound PWM outputs.
- A time-multiplexed sweep, started at each cycle strobe, computes rise/fall edge times into a shadow bank.
- At the next strobe the shadow bank is swapped into the active bank.
- The active bank is compared against a shared period counter.

---
 rtl/pwm_pkg.sv | 39 +++
 rtl/pwm_timing_gen_if.sv | 27 ++
 rtl/pwm_edge_calc.sv | 80 ++++++++
 rtl/pwm_timing_gen.sv | 145 ++++++++++++++
 tb/tb_pwm_timing_gen.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// Shared types for pwm_timing_gen: drive mode, per-channel edge descriptor,
// sweep FSM states and the channel comparator used against the period counter.
package pwm_pkg;

    localparam int PWM_WIDTH = 13;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        EDGE = 2'd1,
        ON   = 2'd2
    } mode_t;

    typedef struct packed {
        logic [PWM_WIDTH-1:0] rise;
        logic [PWM_WIDTH-1:0] fall;
        mode_t                mode;
    } edge_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A wrapped window (rise > fall) is high across the period boundary.
    function automatic logic edge_high(edge_t e, logic [PWM_WIDTH-1:0] cnt);
        logic hi;
        hi = 1'b0;
        case (e.mode)
            OFF:     hi = 1'b0;
            ON:      hi = 1'b1;
            EDGE:    hi = (e.rise < e.fall) ? (cnt >= e.rise && cnt < e.fall)
                                            : (cnt >= e.rise || cnt < e.fall);
            default: hi = 1'b0;
        endcase
        return hi;
    endfunction

endpackage

// File: rtl/pwm_timing_gen_if.sv
// Drive interface between the smoothing stage (master) and pwm_timing_gen (slave).
// PWM_OVERRUN_CNT_EN adds the saturating overrun counter output.
interface pwm_timing_gen_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
);
    logic             start;
    logic [WIDTH-1:0] cycle;
    logic [WIDTH-1:0] duty_s  [DEPTH];
    logic [WIDTH-1:0] phase_s [DEPTH];
    logic [DEPTH-1:0] pwm_out;
    logic             ready;
    logic             overrun;
`ifdef PWM_OVERRUN_CNT_EN
    logic [15:0]      overrun_cnt;

    modport master (output start, cycle, duty_s, phase_s,
                    input  pwm_out, ready, overrun, overrun_cnt);
    modport slave  (input  start, cycle, duty_s, phase_s,
                    output pwm_out, ready, overrun, overrun_cnt);
`else
    modport master (output start, cycle, duty_s, phase_s,
                    input  pwm_out, ready, overrun);
    modport slave  (input  start, cycle, duty_s, phase_s,
                    output pwm_out, ready, overrun);
`endif
endinterface

// File: rtl/pwm_edge_calc.sv
// Two-stage pipeline turning one channel's duty/phase into rise/fall edge times
// centred on the phase; results carry their channel index to the shadow bank.
module pwm_edge_calc
    import pwm_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [PWM_WIDTH-1:0] cycle,
    input  logic                 in_valid,
    input  logic [IDX_W-1:0]     in_idx,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic [PWM_WIDTH-1:0] phase,
    output logic                 out_valid,
    output logic [IDX_W-1:0]     out_idx,
    output edge_t                out_edge
);
    localparam int W = PWM_WIDTH;

    logic [W-1:0]     p_c, h_lo_c, h_hi_c;
    mode_t            mode_c;

    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic [W-1:0]     s1_p, s1_h_lo, s1_h_hi;
    mode_t            s1_mode;

    logic [W:0]       rise_x, fall_x;

    always_comb begin
        p_c    = (phase >= cycle) ? '0 : phase;
        h_lo_c = duty >> 1;
        h_hi_c = duty - h_lo_c;
        if (duty == '0)         mode_c = OFF;
        else if (duty >= cycle) mode_c = ON;
        else                    mode_c = EDGE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_p     <= '0;
            s1_h_lo  <= '0;
            s1_h_hi  <= '0;
            s1_mode  <= OFF;
        end else begin
            s1_valid <= in_valid & ~flush;
            s1_idx   <= in_idx;
            s1_p     <= p_c;
            s1_h_lo  <= h_lo_c;
            s1_h_hi  <= h_hi_c;
            s1_mode  <= mode_c;
        end
    end

    // NOTE: combinational blocks use blocking '=' so each later line sees the
    // value just computed; registers use '<=' so all flops update together.
    always_comb begin
        rise_x = {1'b0, s1_p} - {1'b0, s1_h_lo};
        if (rise_x[W]) rise_x = rise_x + {1'b0, cycle};
        fall_x = {1'b0, s1_p} + {1'b0, s1_h_hi};
        if (fall_x >= {1'b0, cycle}) fall_x = fall_x - {1'b0, cycle};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_edge  <= '{rise: '0, fall: '0, mode: OFF};
        end else begin
            out_valid <= s1_valid & ~flush;
            out_idx   <= s1_idx;
            out_edge  <= '{rise: rise_x[W-1:0], fall: fall_x[W-1:0], mode: s1_mode};
        end
    end

endmodule

// File: rtl/pwm_timing_gen.sv
// Multi-channel ultrasound PWM generator: a START-triggered sweep fills a shadow
// edge bank, swapped in at the next START. PWM_OVERRUN_CNT_EN adds overrun_cnt.
module pwm_timing_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH,
    parameter int DEPTH = 249
) (
    input  logic            clk,
    input  logic            rst_n,
    pwm_timing_gen_if.slave bus
);
    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           state_q, state_d;
    logic             start_d, start_edge;
    logic [WIDTH-1:0] cnt;
    logic [IDX_W-1:0] issue_idx;
    logic             issue_end, issue_valid;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    edge_t            wb_edge;
    logic             ready_q, overrun_q;
    logic             swap, ready_set, overrun_set;
    edge_t            active [DEPTH];
    edge_t            shadow [DEPTH];
    logic [DEPTH-1:0] hi_vec, pwm_q;

    assign start_edge = bus.start & ~start_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d <= 1'b0;
            cnt     <= '0;
        end else begin
            start_d <= bus.start;
            if (start_edge)                         cnt <= '0;
            else if (cnt == bus.cycle - WIDTH'(1))  cnt <= '0;
            else                                    cnt <= cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A START edge mid-sweep restarts the sweep rather than completing it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_edge) state_d = CALC;
            CALC: begin
                if (start_edge)                             state_d = CALC;
                else if (wb_valid && wb_idx == LAST_IDX)    state_d = DONE;
            end
            default:                                        state_d = IDLE;
        endcase
    end

    always_comb begin
        issue_valid = (state_q == CALC) && !issue_end;
        overrun_set = start_edge && (state_q == CALC);
        swap        = start_edge && ready_q;
        ready_set   = (state_q == CALC) && (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_idx <= '0;
            issue_end <= 1'b0;
        end else if (start_edge) begin
            issue_idx <= '0;
            issue_end <= 1'b0;
        end else if (issue_valid) begin
            if (issue_idx == LAST_IDX) issue_end <= 1'b1;
            else                       issue_idx <= issue_idx + IDX_W'(1);
        end
    end

    pwm_edge_calc #(.IDX_W(IDX_W)) u_edge_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_edge),
        .cycle     (bus.cycle),
        .in_valid  (issue_valid),
        .in_idx    (issue_idx),
        .duty      (bus.duty_s[issue_idx]),
        .phase     (bus.phase_s[issue_idx]),
        .out_valid (wb_valid),
        .out_idx   (wb_idx),
        .out_edge  (wb_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_set;
            if (ready_set)       ready_q <= 1'b1;
            else if (start_edge) ready_q <= 1'b0;
        end
    end

    // NOTE: the shadow bank has no reset; READY guarantees it is fully written
    // before it can ever be swapped into the active bank.
    always_ff @(posedge clk) begin
        if (wb_valid) shadow[wb_idx] <= wb_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) active[i] <= '{rise: '0, fall: '0, mode: OFF};
        end else if (swap) begin
            active <= shadow;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_chan
        assign hi_vec[g] = edge_high(active[g], cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= hi_vec;
    end

    assign bus.pwm_out = pwm_q;
    assign bus.ready   = ready_q;
    assign bus.overrun = overrun_q;

`ifdef PWM_OVERRUN_CNT_EN
    logic [15:0] ovr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              ovr_cnt <= '0;
        else if (overrun_q && ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
    end

    assign bus.overrun_cnt = ovr_cnt;
`endif

endmodule

// File: tb/tb_pwm_timing_gen.sv
// Self-checking bench for pwm_timing_gen: a period-level model checked every
// cycle, plus hand-computed edge probes, latency, overrun and reset checks.
module tb_pwm_timing_gen;
    localparam int W = 13;
    localparam int N = 249;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_timing_gen_if #(.WIDTH(W), .DEPTH(N)) bus ();
    pwm_timing_gen #(.WIDTH(W), .DEPTH(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int edge_cyc = 0;
    int ovr_seen = 0;

    int           act_d [N];
    int           act_p [N];
    int           sh_d  [N];
    int           sh_p  [N];
    bit           m_start_d, m_busy, m_ready, m_ovr;
    int           m_cnt, m_k;
    logic [N-1:0] m_pwm;

    typedef struct { int n; int ch; int v; } probe_t;
    probe_t probes [17] = '{
        '{3, 2, 0},    '{3, 3, 1},    '{100, 1, 0},  '{101, 1, 1},  '{102, 1, 0},
        '{500, 4, 1},  '{501, 4, 0},  '{1250, 0, 1}, '{1251, 0, 0}, '{2500, 2, 0},
        '{2500, 3, 1}, '{3750, 0, 0}, '{3751, 0, 1}, '{4500, 4, 0}, '{4501, 4, 1},
        '{5000, 0, 1}, '{5000, 1, 0}
    };

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // High iff the counter lies within D clocks starting at (phase - D/2) mod C.
    function automatic bit ch_high(int d, int p, int cnt, int c);
        int pc;
        if (d <= 0) return 1'b0;
        if (d >= c) return 1'b1;
        pc = (p >= c) ? 0 : p;
        return ((cnt - pc + d / 2 + 2 * c) % c) < d;
    endfunction

    task automatic model_reset();
        m_start_d = 1'b0;
        m_busy    = 1'b0;
        m_ready   = 1'b0;
        m_ovr     = 1'b0;
        m_cnt     = 0;
        m_k       = 0;
        m_pwm     = '0;
        for (int i = 0; i < N; i++) begin
            act_d[i] = 0;
            act_p[i] = 0;
        end
    endtask

    task automatic model_step();
        bit           e;
        int           c;
        logic [N-1:0] np;
        c = int'(bus.cycle);
        e = bus.start && !m_start_d;
        for (int i = 0; i < N; i++) np[i] = ch_high(act_d[i], act_p[i], m_cnt, c);
        m_ovr     = e && m_busy;
        m_start_d = bus.start;
        m_cnt     = e ? 0 : ((m_cnt == c - 1) ? 0 : m_cnt + 1);
        if (e && m_ready) begin
            act_d   = sh_d;
            act_p   = sh_p;
            m_ready = 1'b0;
        end
        if (e) begin
            m_busy   = 1'b1;
            m_k      = 0;
            edge_cyc = cyc;
        end else if (m_busy) begin
            m_k++;
            if (m_k == N + 2) begin
                m_busy  = 1'b0;
                m_ready = 1'b1;
                for (int i = 0; i < N; i++) begin
                    sh_d[i] = int'(bus.duty_s[i]);
                    sh_p[i] = int'(bus.phase_s[i]);
                end
            end
        end
        m_pwm = np;
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else        model_step();
        checks++;
        if (bus.pwm_out !== m_pwm || bus.ready !== m_ready || bus.overrun !== m_ovr) begin
            errors++;
            $display("FAIL model cyc=%0d pwm_xor=%h ready got %b exp %b overrun got %b exp %b",
                     cyc, bus.pwm_out ^ m_pwm, bus.ready, m_ready, bus.overrun, m_ovr);
        end
        if (bus.overrun === 1'b1) ovr_seen++;
    end

    task automatic load_random(input int c);
        for (int i = 0; i < N; i++) begin
            bus.duty_s[i]  = W'($urandom_range(0, c));
            bus.phase_s[i] = W'($urandom_range(0, c));
        end
    endtask

    task automatic set_ch(input int i, input int d, input int p);
        bus.duty_s[i]  = W'(d);
        bus.phase_s[i] = W'(p);
    endtask

    task automatic start_pulse();
        @(negedge clk) bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_ready(input int bound, output int lat);
        while (bus.ready !== 1'b1 && (cyc - edge_cyc) < bound) begin
            @(posedge clk);
            #2;
        end
        lat = cyc - edge_cyc;
    endtask

    initial begin
        int lat;
        int n;
        int hc [N];
        int bad;
        int exp_hi;

        bus.start = 1'b0;
        bus.cycle = W'(5000);
        for (int i = 0; i < N; i++) set_ch(i, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("reset pwm_out nonzero", int'(bus.pwm_out != '0), 0);
        check("reset ready", int'(bus.ready), 0);
        check("reset overrun", int'(bus.overrun), 0);
        @(negedge clk) rst_n = 1'b1;

        // Directed channels at CYCLE=5000, the rest random in [0,CYCLE].
        load_random(5000);
        set_ch(0, 2500, 0);
        set_ch(1, 1, 100);
        set_ch(2, 0, 77);
        set_ch(3, 5000, 1234);
        set_ch(4, 1000, 5000);
        start_pulse();
        wait_ready(N + 20, lat);
        check("ready latency first sweep", lat, N + 2);

        start_pulse();
        for (int j = 0; j < N; j++) hc[j] = 0;
        while (cyc - edge_cyc < 5002) begin
            @(posedge clk);
            #2;
            n = cyc - edge_cyc;
            for (int j = 0; j < 5; j++) hc[j] += int'(bus.pwm_out[j]);
            foreach (probes[q])
                if (probes[q].n == n)
                    check($sformatf("ch%0d at cnt %0d", probes[q].ch, n - 1),
                          int'(bus.pwm_out[probes[q].ch]), probes[q].v);
        end
        check("ch0 highs per period", hc[0], 2500);
        check("ch1 highs per period", hc[1], 1);
        check("ch2 highs per period", hc[2], 0);
        check("ch3 highs per period", hc[3], 5000);
        check("ch4 highs per period", hc[4], 1000);

        // START edges DEPTH clocks apart: every edge after the first overruns.
        check("ready before overrun run", int'(bus.ready), 1);
        ovr_seen = 0;
        start_pulse();
        for (int j = 0; j < 4; j++) begin
            repeat (N - 4) @(negedge clk);
            load_random(5000);
            bus.duty_s[0] = '0;
            start_pulse();
        end
        wait_ready(N + 20, lat);
        check("ready latency after overruns", lat, N + 2);
        check("overrun pulses", ovr_seen, 4);
`ifdef PWM_OVERRUN_CNT_EN
        check("overrun_cnt", int'(bus.overrun_cnt), 4);
`endif
        start_pulse();
        repeat (600) @(negedge clk);

        // Reset in the middle of a sweep while the outputs are toggling.
        start_pulse();
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset pwm_out nonzero", int'(bus.pwm_out != '0), 0);
        check("async reset ready", int'(bus.ready), 0);
        check("async reset overrun", int'(bus.overrun), 0);
`ifdef PWM_OVERRUN_CNT_EN
        check("async reset overrun_cnt", int'(bus.overrun_cnt), 0);
`endif

        bus.cycle = W'(300);
        load_random(300);
        set_ch(0, 300, 12);
        set_ch(1, 0, 40);
        set_ch(2, 150, 300);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_pulse();
        wait_ready(N + 20, lat);
        check("ready latency after reset", lat, N + 2);
        start_pulse();

        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < N; j++) hc[j] = 0;
            repeat (300) begin
                @(posedge clk);
                #2;
                for (int j = 0; j < N; j++) hc[j] += int'(bus.pwm_out[j]);
            end
            bad    = -1;
            exp_hi = 0;
            for (int j = 0; j < N; j++) begin
                if (bad < 0 && hc[j] != ((int'(bus.duty_s[j]) > 300) ? 300 : int'(bus.duty_s[j]))) begin
                    bad    = j;
                    exp_hi = (int'(bus.duty_s[j]) > 300) ? 300 : int'(bus.duty_s[j]);
                end
            end
            checks++;
            if (bad >= 0) begin
                errors++;
                $display("FAIL period %0d highs ch%0d: got %0d expected %0d", k, bad, hc[bad], exp_hi);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
